axi_mem_responder: RTL and testbench

- AXI4 subordinate with flop-array storage. Answers the core's AXI4+ATOP manager port: AddrWidth 64, DataWidth 64, IdWidth 4, UserWidth 32.
- Used as boot-ROM/scratch memory in embedded testbenches and small SoCs.
- Serves INCR/FIXED read bursts, which cover cache-line refills (128-bit line = 2 beats).
- Accepts single-beat writes only, matching the core's write-burst-disabled configuration.
- Rejects atomics; RVA is off in this configuration.

---
 rtl/axi_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a flop array. Serves INCR/FIXED read bursts,
// single-beat writes only; atomics, write bursts and reserved bursts get SLVERR.
module axi_mem_responder #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          UserWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = 'h1_0000,
  parameter int unsigned          NumWords  = 2048
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic [5:0]             aw_atop_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  output logic [UserWidth-1:0]   b_user_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic [UserWidth-1:0]   r_user_o
);

  localparam int unsigned          BeatBytes = DataWidth / 8;
  localparam int unsigned          OffW      = $clog2(BeatBytes);
  localparam int unsigned          IdxW      = $clog2(NumWords);
  localparam logic [AddrWidth-1:0] MemBytes  = AddrWidth'(NumWords * BeatBytes);
  localparam logic [AddrWidth-1:0] BeatMask  = ~AddrWidth'(BeatBytes - 1);

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  typedef enum logic       {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return (addr >= BaseAddr) && ((addr - BaseAddr) < MemBytes);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] addr);
    return IdxW'((addr - BaseAddr) >> OffW);
  endfunction

  logic [DataWidth-1:0] mem [NumWords];

  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q;
  logic [AddrWidth-1:0] r_addr_q;
  logic [7:0]           r_len_q, r_cnt_q;
  logic [1:0]           r_burst_q;
  logic [2:0]           r_size_q;
  logic                 ar_hs, r_hs, r_last, r_slverr, r_decerr;

  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q;
  logic [AddrWidth-1:0] w_addr_q;
  logic [7:0]           w_len_q, w_cnt_q;
  logic                 w_err_q, w_mis_q;
  logic                 aw_hs, w_hs, b_hs, w_we;

  // aw_size is not needed: only full single beats are ever committed
  logic unused_aw_size;
  assign unused_aw_size = ^aw_size_i;

  assign ar_hs    = ar_valid_i && ar_ready_o;
  assign r_hs     = r_valid_o && r_ready_i;
  assign r_last   = (r_cnt_q == r_len_q);
  assign r_decerr = !in_range(r_addr_q);
  // WRAP and reserved bursts, or narrow multi-beat bursts, fail every beat
  assign r_slverr = r_burst_q[1] || ((r_len_q != 8'd0) && (r_size_q != 3'(OffW)));

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i && w_ready_o;
  assign b_hs  = b_valid_o && b_ready_i;
  assign w_we  = w_hs && !w_err_q && in_range(w_addr_q) && (w_cnt_q == 8'd0);

  // Read FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state_q <= R_IDLE;
    else         r_state_q <= r_state_d;
  end

  // Read FSM next state: leave the burst only after the last beat is taken
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_hs && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read outputs: payload is zero outside a burst, data only on OKAY beats
  always_comb begin
    ar_ready_o = (r_state_q == R_IDLE);
    r_valid_o  = (r_state_q == R_BURST);
    r_id_o     = '0;
    r_data_o   = '0;
    r_resp_o   = RespOkay;
    r_last_o   = 1'b0;
    r_user_o   = '0;
    if (r_state_q == R_BURST) begin
      r_id_o   = r_id_q;
      r_last_o = r_last;
      if (r_decerr)      r_resp_o = RespDecErr;
      else if (r_slverr) r_resp_o = RespSlvErr;
      else               r_data_o = mem[word_idx(r_addr_q)];
    end
  end

  // Read burst context: captured on AR, advanced on each R handshake
  always_ff @(posedge clk_i) begin
    if (ar_hs) begin
      r_id_q    <= ar_id_i;
      r_addr_q  <= ar_addr_i;
      r_len_q   <= ar_len_i;
      r_burst_q <= ar_burst_i;
      r_size_q  <= ar_size_i;
      r_cnt_q   <= 8'd0;
    end else if (r_hs) begin
      r_cnt_q <= r_cnt_q + 8'd1;
      if (r_burst_q == 2'b01) r_addr_q <= (r_addr_q + AddrWidth'(BeatBytes)) & BeatMask;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) w_state_q <= W_IDLE;
    else         w_state_q <= w_state_d;
  end

  // Write FSM next state: W_DATA drains until wlast regardless of errors
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_i) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write outputs: SLVERR outranks DECERR
  always_comb begin
    aw_ready_o = (w_state_q == W_IDLE);
    w_ready_o  = (w_state_q == W_DATA);
    b_valid_o  = (w_state_q == W_RESP);
    b_id_o     = '0;
    b_resp_o   = RespOkay;
    b_user_o   = '0;
    if (w_state_q == W_RESP) begin
      b_id_o = w_id_q;
      if (w_err_q || w_mis_q)  b_resp_o = RespSlvErr;
      else if (!in_range(w_addr_q)) b_resp_o = RespDecErr;
    end
  end

  // Write transaction context and sticky last/length mismatch flag
  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      w_id_q   <= aw_id_i;
      w_addr_q <= aw_addr_i;
      w_len_q  <= aw_len_i;
      w_err_q  <= (aw_len_i != 8'd0) || (aw_atop_i != 6'd0) || (aw_burst_i == 2'b11);
      w_cnt_q  <= 8'd0;
      w_mis_q  <= 1'b0;
    end else if (w_hs) begin
      w_cnt_q <= w_cnt_q + 8'd1;
      if (w_last_i != (w_cnt_q == w_len_q)) w_mis_q <= 1'b1;
    end
  end

  // Byte-strobed storage write; readers see the new word from the next cycle
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int unsigned b = 0; b < BeatBytes; b++) begin
        if (w_strb_i[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a table of single-beat write/read
// transactions plus hand-written burst, stall, error and reset sequences.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [5:0]  aw_atop;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [31:0] b_user;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [31:0] r_user;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst), .aw_atop_i(aw_atop),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .b_user_o(b_user),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .r_user_o(r_user)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [5:0] atop, input logic [63:0] data,
                          input logic [7:0] strb, input int nbeats, input logic [1:0] exp_resp,
                          input string name);
    @(negedge clk);
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3;
    aw_burst = burst; aw_atop = atop;
    for (int k = 0; k < 20 && !aw_ready; k++) @(negedge clk);
    chk({name, " aw_ready"}, 64'(aw_ready), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      w_valid = 1'b1; w_data = data; w_strb = strb; w_last = (b == nbeats - 1);
      for (int k = 0; k < 20 && !w_ready; k++) @(negedge clk);
      chk({name, " w_ready"}, 64'(w_ready), 64'd1);
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    for (int k = 0; k < 20 && !b_valid; k++) @(negedge clk);
    chk({name, " b_valid"}, 64'(b_valid), 64'd1);
    chk({name, " b_id"}, 64'(b_id), 64'(id));
    chk({name, " b_resp"}, 64'(b_resp), 64'(exp_resp));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk({name, " b_valid drop"}, 64'(b_valid), 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int stall0,
                         input logic [63:0] ed[4], input logic [1:0] er[4], input string name);
    @(negedge clk);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    for (int k = 0; k < 20 && !ar_ready; k++) @(negedge clk);
    chk({name, " ar_ready"}, 64'(ar_ready), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    chk({name, " r_valid latency"}, 64'(r_valid), 64'd1);
    for (int s = 0; s < stall0; s++) begin
      chk({name, " stall r_valid"}, 64'(r_valid), 64'd1);
      chk({name, " stall r_data"}, r_data, ed[0]);
      chk({name, " stall r_last"}, 64'(r_last), 64'(len == 8'd0));
      @(negedge clk);
    end
    for (int b = 0; b <= int'(len); b++) begin
      for (int k = 0; k < 20 && !r_valid; k++) @(negedge clk);
      chk($sformatf("%s beat%0d r_valid", name, b), 64'(r_valid), 64'd1);
      chk($sformatf("%s beat%0d r_id", name, b), 64'(r_id), 64'(id));
      chk($sformatf("%s beat%0d r_data", name, b), r_data, ed[b]);
      chk($sformatf("%s beat%0d r_resp", name, b), 64'(r_resp), 64'(er[b]));
      chk($sformatf("%s beat%0d r_last", name, b), 64'(r_last), 64'(b == int'(len)));
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
    end
    chk({name, " r_valid drop"}, 64'(r_valid), 64'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, " aw_ready"}, 64'(aw_ready), 64'd1);
    chk({name, " ar_ready"}, 64'(ar_ready), 64'd1);
    chk({name, " w_ready"},  64'(w_ready),  64'd0);
    chk({name, " b_valid"},  64'(b_valid),  64'd0);
    chk({name, " r_valid"},  64'(r_valid),  64'd0);
    chk({name, " r_payload"}, {r_data[31:0], r_id, r_resp, r_last, r_user[24:0]}, 64'd0);
    chk({name, " b_payload"}, {26'd0, b_id, b_resp, b_user}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ed[4];
    logic [1:0]  er[4];

    rst_ni = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_atop = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    chk_idle("post-reset");

    //          wr  id     addr             burst atop   data                   strb   resp  exp_data
    vecs[0]  = '{1, 4'h3, 64'h1_0008, 2'd1, 6'h00, 64'h1122334455667788, 8'hFF, 2'd0, 64'h0};
    vecs[1]  = '{0, 4'h5, 64'h1_0008, 2'd1, 6'h00, 64'h0,                8'h00, 2'd0, 64'h1122334455667788};
    vecs[2]  = '{1, 4'h1, 64'h1_0010, 2'd1, 6'h00, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'd0, 64'h0};
    vecs[3]  = '{1, 4'h1, 64'h1_0010, 2'd1, 6'h00, 64'h0,                8'h0F, 2'd0, 64'h0};
    vecs[4]  = '{0, 4'h2, 64'h1_0010, 2'd1, 6'h00, 64'h0,                8'h00, 2'd0, 64'hFFFFFFFF00000000};
    vecs[5]  = '{1, 4'h4, 64'h1_0000, 2'd1, 6'h00, 64'hA5A5000000000001, 8'hFF, 2'd0, 64'h0};
    vecs[6]  = '{0, 4'h6, 64'h1_0000, 2'd1, 6'h00, 64'h0,                8'h00, 2'd0, 64'hA5A5000000000001};
    vecs[7]  = '{1, 4'h9, 64'h1_0008, 2'd1, 6'h20, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'd2, 64'h0};
    vecs[8]  = '{0, 4'hA, 64'h1_0008, 2'd1, 6'h00, 64'h0,                8'h00, 2'd0, 64'h1122334455667788};
    vecs[9]  = '{0, 4'hB, 64'h0,      2'd1, 6'h00, 64'h0,                8'h00, 2'd3, 64'h0};
    vecs[10] = '{1, 4'hC, 64'h1_4000, 2'd1, 6'h00, 64'h77,               8'hFF, 2'd3, 64'h0};
    vecs[11] = '{1, 4'hD, 64'h1_3FFC, 2'd1, 6'h00, 64'h0123456789ABCDEF, 8'hFF, 2'd0, 64'h0};
    vecs[12] = '{0, 4'hE, 64'h1_3FF8, 2'd1, 6'h00, 64'h0,                8'h00, 2'd0, 64'h0123456789ABCDEF};
    vecs[13] = '{0, 4'hF, 64'h1_0008, 2'd2, 6'h00, 64'h0,                8'h00, 2'd2, 64'h0};
    vecs[14] = '{1, 4'h2, 64'h1_0018, 2'd3, 6'h00, 64'h55,               8'hFF, 2'd2, 64'h0};
    vecs[15] = '{0, 4'h0, 64'h0_FFF8, 2'd1, 6'h00, 64'h0,                8'h00, 2'd3, 64'h0};

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].burst, vecs[i].atop, vecs[i].data,
                 vecs[i].strb, 1, vecs[i].exp_resp, $sformatf("vec%0d", i));
      end else begin
        ed = '{vecs[i].exp_data, 64'h0, 64'h0, 64'h0};
        er = '{vecs[i].exp_resp, 2'd0, 2'd0, 2'd0};
        do_read(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].burst, 3'd3, 0, ed, er,
                $sformatf("vec%0d", i));
      end
    end

    // W data presented before any AW must not be accepted
    @(negedge clk);
    w_valid = 1'b1; w_last = 1'b1; w_strb = 8'hFF; w_data = 64'h0;
    @(negedge clk);
    chk("early W w_ready", 64'(w_ready), 64'd0);
    w_valid = 1'b0; w_last = 1'b0;

    // Line refill with three stalled cycles on beat 0
    ed = '{64'hA5A5000000000001, 64'h1122334455667788, 64'h0, 64'h0};
    er = '{2'd0, 2'd0, 2'd0, 2'd0};
    do_read(4'h7, 64'h1_0000, 8'd1, 2'd1, 3'd3, 3, ed, er, "refill");

    // Unaligned INCR start realigns to the next beat
    do_read(4'h8, 64'h1_0004, 8'd1, 2'd1, 3'd3, 0, ed, er, "unaligned incr");

    // FIXED burst repeats the same word
    ed = '{64'h1122334455667788, 64'h1122334455667788, 64'h0, 64'h0};
    do_read(4'h9, 64'h1_0008, 8'd1, 2'd0, 3'd3, 0, ed, er, "fixed");

    // Narrow multi-beat read fails on every beat
    ed = '{64'h0, 64'h0, 64'h0, 64'h0};
    er = '{2'd2, 2'd2, 2'd0, 2'd0};
    do_read(4'hA, 64'h1_0000, 8'd1, 2'd1, 3'd2, 0, ed, er, "narrow burst");

    // INCR burst running off the end of memory
    ed = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0};
    er = '{2'd0, 2'd3, 2'd0, 2'd0};
    do_read(4'hB, 64'h1_3FF8, 8'd1, 2'd1, 3'd3, 0, ed, er, "end crossing");

    // Two-beat write burst is drained and rejected without touching storage
    do_write(4'h6, 64'h1_0000, 8'd1, 2'd1, 6'h00, 64'h0BAD0BAD0BAD0BAD, 8'hFF, 2, 2'd2, "wburst");
    ed = '{64'hA5A5000000000001, 64'h0, 64'h0, 64'h0};
    er = '{2'd0, 2'd0, 2'd0, 2'd0};
    do_read(4'hC, 64'h1_0000, 8'd0, 2'd1, 3'd3, 0, ed, er, "wburst readback");

    // Missing wlast on a single-beat write: drained until wlast, SLVERR
    do_write(4'h5, 64'h1_0010, 8'd0, 2'd1, 6'h00, 64'h0, 8'hFF, 2, 2'd2, "late wlast");

    // Reset while a read burst is outstanding
    @(negedge clk);
    ar_valid = 1'b1; ar_id = 4'h3; ar_addr = 64'h1_0000; ar_len = 8'd3;
    ar_size = 3'd3; ar_burst = 2'd1;
    for (int k = 0; k < 20 && !ar_ready; k++) @(negedge clk);
    @(negedge clk);
    ar_valid = 1'b0;
    chk("mid-read r_valid", 64'(r_valid), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid-read reset r_valid", 64'(r_valid), 64'd0);
    chk("mid-read reset ar_ready", 64'(ar_ready), 64'd1);
    rst_ni = 1'b1;
    r_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset no beat %0d", c), 64'(r_valid), 64'd0);
    end
    r_ready = 1'b0;

    // Storage survives reset
    ed = '{64'h1122334455667788, 64'h0, 64'h0, 64'h0};
    do_read(4'hD, 64'h1_0008, 8'd0, 2'd1, 3'd3, 0, ed, er, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
